burst_write_master: RTL and testbench

BURST_WRITE_MASTER -- requirements
Module: burst_write_master

---
 rtl/burst_write_master_if.sv | 41 ++++
 rtl/burst_write_master.sv | 152 +++++++++++++++
 tb/tb_burst_write_master.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_write_master_if.sv
// Bus bundle for burst_write_master: control/status, show-ahead FIFO read side
// and the Avalon-MM burst write master port.
interface burst_write_master_if #(
   parameter int DATA_W    = 32,
   parameter int BURST_MAX = 8,
   parameter int USEDW_W   = 9
);
   localparam int BYTES = DATA_W / 8;
   localparam int BC_W  = $clog2(BURST_MAX) + 1;

   logic                Start;
   logic                Stop;
   logic [31:0]         Length;
   logic [31:0]         WM_startaddress;
   logic                FF_empty;
   logic [USEDW_W-1:0]  FF_usedw;
   logic [DATA_W-1:0]   FF_q;
   logic                FF_readrequest;
   logic                oWM_write;
   logic [31:0]         oWM_writeaddress;
   logic [BC_W-1:0]     oWM_burstcount;
   logic [DATA_W-1:0]   oWM_writedata;
   logic [BYTES-1:0]    oWM_byteenable;
   logic                iWM_waitrequest;
   logic                WM_busy;
   logic                WM_done;

   modport master (
      input  Start, Stop, Length, WM_startaddress,
      input  FF_empty, FF_usedw, FF_q, iWM_waitrequest,
      output FF_readrequest, oWM_write, oWM_writeaddress, oWM_burstcount,
      output oWM_writedata, oWM_byteenable, WM_busy, WM_done
   );

   modport slave (
      output Start, Stop, Length, WM_startaddress,
      output FF_empty, FF_usedw, FF_q, iWM_waitrequest,
      input  FF_readrequest, oWM_write, oWM_writeaddress, oWM_burstcount,
      input  oWM_writedata, oWM_byteenable, WM_busy, WM_done
   );
endinterface

// File: rtl/burst_write_master.sv
// Moves Length bytes from a show-ahead FIFO to memory as Avalon-MM write bursts
// of up to BURST_MAX beats, only launching a burst once the FIFO holds all of it.
module burst_write_master #(
   parameter int DATA_W    = 32,
   parameter int BURST_MAX = 8,
   parameter int USEDW_W   = 9
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   burst_write_master_if.master  bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int LOG_B = $clog2(BYTES);
   localparam int BC_W  = $clog2(BURST_MAX) + 1;
   localparam logic [BYTES-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {IDLE, WAIT_FIFO, BURST, COMPLETE} state_t;

   state_t            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       beats_left_q, beats_left_d;
   logic [LOG_B-1:0]  tail_q, tail_d;
   logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic              last_burst_q, last_burst_d;
   logic              stop_seen_q, stop_seen_d;
   logic [31:0]       wr_addr_q, wr_addr_d;
   logic [BC_W-1:0]   burstcount_q, burstcount_d;
   logic              write_q, write_d;
   logic [BYTES-1:0]  be_q, be_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              accept;
   logic [BC_W-1:0]   n_calc;
   logic [BYTES-1:0]  tail_mask;
   logic              entry_last;

   assign accept    = write_q & ~bus.iWM_waitrequest;
   assign n_calc    = (beats_left_q >= 32'(BURST_MAX)) ? BC_W'(BURST_MAX) : beats_left_q[BC_W-1:0];
   assign tail_mask = ~(ALL_ONES << tail_q);
   assign entry_last = (32'(n_calc) == beats_left_q);

   // BURST has two phases: beats while write_q is high, then one burst-end
   // cycle with write_q low where the address and remaining count advance.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beats_left_d = beats_left_q;
      tail_d       = tail_q;
      beat_cnt_d   = beat_cnt_q;
      last_burst_d = last_burst_q;
      stop_seen_d  = stop_seen_q;
      wr_addr_d    = wr_addr_q;
      burstcount_d = burstcount_q;
      write_d      = write_q;
      be_d         = be_q;
      done_d       = done_q;
      unique case (state_q)
         IDLE: begin
            if (bus.Start) begin
               addr_d       = bus.WM_startaddress;
               beats_left_d = 32'(bus.Length >> LOG_B) + 32'(|bus.Length[LOG_B-1:0]);
               tail_d       = bus.Length[LOG_B-1:0];
               done_d       = 1'b0;
               state_d      = (bus.Length == 32'd0) ? COMPLETE : WAIT_FIFO;
            end
         end
         WAIT_FIFO: begin
            if (bus.Stop) begin
               state_d = COMPLETE;
            end else if (32'(bus.FF_usedw) >= 32'(n_calc)) begin
               state_d      = BURST;
               wr_addr_d    = addr_q;
               burstcount_d = n_calc;
               write_d      = 1'b1;
               beat_cnt_d   = '0;
               stop_seen_d  = 1'b0;
               last_burst_d = entry_last;
               be_d         = (entry_last && n_calc == BC_W'(1) && tail_q != '0) ? tail_mask : ALL_ONES;
            end
         end
         BURST: begin
            if (bus.Stop) stop_seen_d = 1'b1;
            if (write_q) begin
               if (accept) begin
                  if (beat_cnt_q == burstcount_q - BC_W'(1)) begin
                     write_d = 1'b0;
                     be_d    = '0;
                  end else begin
                     beat_cnt_d = beat_cnt_q + BC_W'(1);
                     // Next beat is the transfer's final one: trim to the tail bytes.
                     be_d = (last_burst_q && (beat_cnt_q + BC_W'(2) == burstcount_q) && tail_q != '0)
                            ? tail_mask : ALL_ONES;
                  end
               end
            end else begin
               addr_d       = addr_q + (32'(burstcount_q) << LOG_B);
               beats_left_d = beats_left_q - 32'(burstcount_q);
               state_d      = (beats_left_q == 32'(burstcount_q) || stop_seen_q || bus.Stop)
                              ? COMPLETE : WAIT_FIFO;
            end
         end
         COMPLETE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         beats_left_q <= '0;
         tail_q       <= '0;
         beat_cnt_q   <= '0;
         last_burst_q <= 1'b0;
         stop_seen_q  <= 1'b0;
         wr_addr_q    <= '0;
         burstcount_q <= '0;
         write_q      <= 1'b0;
         be_q         <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         beats_left_q <= beats_left_d;
         tail_q       <= tail_d;
         beat_cnt_q   <= beat_cnt_d;
         last_burst_q <= last_burst_d;
         stop_seen_q  <= stop_seen_d;
         wr_addr_q    <= wr_addr_d;
         burstcount_q <= burstcount_d;
         write_q      <= write_d;
         be_q         <= be_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.FF_readrequest   = accept;
   assign bus.oWM_write        = write_q;
   assign bus.oWM_writeaddress = wr_addr_q;
   assign bus.oWM_burstcount   = burstcount_q;
   assign bus.oWM_writedata    = bus.FF_q;
   assign bus.oWM_byteenable   = be_q;
   assign bus.WM_busy          = busy_q;
   assign bus.WM_done          = done_q;
endmodule

// File: tb/tb_burst_write_master.sv
// Bench for burst_write_master: FIFO model, beat logger and a burst-splitting
// reference model driven through directed and randomized transfers.
module tb_burst_write_master;
   localparam int DATA_W    = 32;
   localparam int BURST_MAX = 8;
   localparam int USEDW_W   = 9;
   localparam int BYTES     = DATA_W / 8;
   localparam int BC_W      = $clog2(BURST_MAX) + 1;

   logic iClk = 1'b0;
   logic iReset_n = 1'b0;
   always #5 iClk = ~iClk;

   burst_write_master_if #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .USEDW_W(USEDW_W)) bus ();

   burst_write_master #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .USEDW_W(USEDW_W)) dut (
      .iClk     (iClk),
      .iReset_n (iReset_n),
      .bus      (bus)
   );

   // Show-ahead FIFO: the main sequence pushes, the clocked process pops.
   logic [DATA_W-1:0] fifoMem [0:1023];
   int unsigned wrPtr = 0;
   int unsigned rdPtr = 0;
   logic flushReq = 1'b0;

   always @(posedge iClk) begin
      if (flushReq) rdPtr <= wrPtr;
      else if (bus.FF_readrequest) rdPtr <= rdPtr + 1;
   end

   assign bus.FF_usedw = USEDW_W'(wrPtr - rdPtr);
   assign bus.FF_empty = (wrPtr == rdPtr);
   assign bus.FF_q     = fifoMem[rdPtr[9:0]];

   // Beat logger and protocol watchers, sampled on the falling edge.
   int beatCount = 0, cycleCount = 0;
   int rrErrors = 0, emptyErrors = 0, stableErrors = 0;
   logic [31:0]       logAddr  [0:1023];
   logic [BC_W-1:0]   logBc    [0:1023];
   logic [DATA_W-1:0] logData  [0:1023];
   logic [BYTES-1:0]  logBe    [0:1023];
   int                logCycle [0:1023];
   logic prevWrite = 1'b0;
   logic [31:0] prevAddr = '0;
   logic [BC_W-1:0] prevBc = '0;

   always @(negedge iClk) begin
      logic acc;
      acc = bus.oWM_write && !bus.iWM_waitrequest;
      cycleCount++;
      if (bus.FF_readrequest !== acc) rrErrors++;
      if (acc && bus.FF_empty) emptyErrors++;
      if (bus.oWM_write && prevWrite &&
          (bus.oWM_writeaddress !== prevAddr || bus.oWM_burstcount !== prevBc)) stableErrors++;
      if (acc) begin
         logAddr[beatCount % 1024]  = bus.oWM_writeaddress;
         logBc[beatCount % 1024]    = bus.oWM_burstcount;
         logData[beatCount % 1024]  = bus.oWM_writedata;
         logBe[beatCount % 1024]    = bus.oWM_byteenable;
         logCycle[beatCount % 1024] = cycleCount;
         beatCount++;
      end
      prevWrite = bus.oWM_write;
      prevAddr  = bus.oWM_writeaddress;
      prevBc    = bus.oWM_burstcount;
   end

   int testsRun = 0, failCount = 0;
   logic [DATA_W-1:0] expData [0:255];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   task automatic pushWords(input int first, input int n);
      for (int k = 0; k < n; k++) begin
         logic [DATA_W-1:0] d;
         d = DATA_W'($urandom);
         expData[first + k] = d;
         fifoMem[wrPtr[9:0]] = d;
         wrPtr = wrPtr + 1;
      end
   endtask

   task automatic flushFifo();
      flushReq = 1'b1;
      step(1);
      flushReq = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] length, input logic [31:0] addr);
      bus.Start = 1'b1;
      bus.Length = length;
      bus.WM_startaddress = addr;
      step(1);
      bus.Start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int limit, input bit randWait);
      int cycles;
      cycles = 0;
      while (bus.WM_done !== 1'b1 && cycles < limit) begin
         bus.iWM_waitrequest = randWait ? 1'($urandom_range(0, 1)) : 1'b0;
         step(1);
         cycles++;
      end
      bus.iWM_waitrequest = 1'b0;
      checkOutput(tag, 64'(bus.WM_done), 64'(1));
   endtask

   // Reference: beat i belongs to burst i/BURST_MAX, bursts are contiguous.
   task automatic checkBeats(input string tag, input int base, input int length,
                             input logic [31:0] addr, input int nExp);
      int beats, tail, burstIdx, remain;
      logic [31:0] expAddr;
      logic [BYTES-1:0] expBe;
      beats = (length + BYTES - 1) / BYTES;
      tail  = length % BYTES;
      checkOutput({tag, "_count"}, 64'(beatCount - base), 64'(nExp));
      for (int i = 0; i < nExp; i++) begin
         burstIdx = i / BURST_MAX;
         remain   = beats - burstIdx * BURST_MAX;
         expAddr  = addr + 32'(burstIdx * BURST_MAX * BYTES);
         expBe    = (i == beats - 1 && tail != 0) ? BYTES'((1 << tail) - 1) : '1;
         checkOutput($sformatf("%s_addr%0d", tag, i), 64'(logAddr[(base + i) % 1024]), 64'(expAddr));
         checkOutput($sformatf("%s_bc%0d", tag, i), 64'(logBc[(base + i) % 1024]),
                     64'(remain < BURST_MAX ? remain : BURST_MAX));
         checkOutput($sformatf("%s_data%0d", tag, i), 64'(logData[(base + i) % 1024]), 64'(expData[i]));
         checkOutput($sformatf("%s_be%0d", tag, i), 64'(logBe[(base + i) % 1024]), 64'(expBe));
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base, len, beats;
      logic [31:0] addr;
      bus.Start = 1'b0;
      bus.Stop = 1'b0;
      bus.Length = '0;
      bus.WM_startaddress = '0;
      bus.iWM_waitrequest = 1'b0;
      step(2);
      checkOutput("rst_write", 64'(bus.oWM_write), 64'(0));
      checkOutput("rst_addr", 64'(bus.oWM_writeaddress), 64'(0));
      checkOutput("rst_bc", 64'(bus.oWM_burstcount), 64'(0));
      checkOutput("rst_be", 64'(bus.oWM_byteenable), 64'(0));
      checkOutput("rst_busy", 64'(bus.WM_busy), 64'(0));
      checkOutput("rst_done", 64'(bus.WM_done), 64'(0));
      iReset_n = 1'b1;
      step(1);

      // Two full bursts, no stalls: exact done latency and inter-burst gap.
      base = beatCount;
      pushWords(0, 16);
      applyStimulus(32'd64, 32'h1000);
      checkOutput("s1_busy", 64'(bus.WM_busy), 64'(1));
      step(20);
      checkOutput("s1_done_early", 64'(bus.WM_done), 64'(0));
      step(1);
      checkOutput("s1_done", 64'(bus.WM_done), 64'(1));
      checkOutput("s1_idle_busy", 64'(bus.WM_busy), 64'(0));
      checkBeats("s1", base, 64, 32'h1000, 16);
      checkOutput("s1_gap", 64'(logCycle[(base + 8) % 1024] - logCycle[(base + 7) % 1024]), 64'(3));

      // Partial tail byte enables.
      base = beatCount;
      pushWords(0, 6);
      applyStimulus(32'd22, 32'h0000_2000);
      waitDone("s2_done", 100, 1'b0);
      checkBeats("s2", base, 22, 32'h0000_2000, 6);
      checkOutput("s2_last_be", 64'(logBe[(base + 5) % 1024]), 64'(4'b0011));

      // Burst held back until the FIFO holds a full burst.
      base = beatCount;
      pushWords(0, 3);
      applyStimulus(32'd40, 32'h0000_5000);
      step(10);
      checkOutput("s3_no_write", 64'(beatCount - base), 64'(0));
      checkOutput("s3_write_low", 64'(bus.oWM_write), 64'(0));
      checkOutput("s3_busy", 64'(bus.WM_busy), 64'(1));
      pushWords(3, 7);
      waitDone("s3_done", 100, 1'b0);
      checkBeats("s3", base, 40, 32'h0000_5000, 10);

      // Randomized transfers under 50% waitrequest, first one wrapping the address.
      for (int t = 0; t < 5; t++) begin
         len   = int'($urandom_range(1, 120));
         addr  = (t == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         beats = (len + BYTES - 1) / BYTES;
         base  = beatCount;
         pushWords(0, beats);
         applyStimulus(32'(len), addr);
         waitDone($sformatf("rnd%0d_done", t), 400, 1'b1);
         checkBeats($sformatf("rnd%0d", t), base, len, addr, beats);
      end

      // Stop during beat 3 finishes the burst and ends the transfer.
      base = beatCount;
      pushWords(0, 16);
      applyStimulus(32'd64, 32'h0000_6000);
      step(3);
      bus.Stop = 1'b1;
      step(1);
      bus.Stop = 1'b0;
      waitDone("s5_done", 60, 1'b0);
      step(5);
      checkBeats("s5", base, 64, 32'h0000_6000, 8);
      checkOutput("s5_left", 64'(bus.FF_usedw), 64'(8));

      // Reset in the middle of a burst, then a zero-length transfer.
      flushFifo();
      pushWords(0, 16);
      applyStimulus(32'd64, 32'h0000_7000);
      step(4);
      iReset_n = 1'b0;
      #1;
      checkOutput("mid_rst_write", 64'(bus.oWM_write), 64'(0));
      checkOutput("mid_rst_rr", 64'(bus.FF_readrequest), 64'(0));
      checkOutput("mid_rst_addr", 64'(bus.oWM_writeaddress), 64'(0));
      checkOutput("mid_rst_bc", 64'(bus.oWM_burstcount), 64'(0));
      checkOutput("mid_rst_be", 64'(bus.oWM_byteenable), 64'(0));
      checkOutput("mid_rst_busy", 64'(bus.WM_busy), 64'(0));
      checkOutput("mid_rst_done", 64'(bus.WM_done), 64'(0));
      step(1);
      iReset_n = 1'b1;
      step(1);
      flushFifo();
      base = beatCount;
      applyStimulus(32'd0, 32'h0000_8000);
      checkOutput("len0_busy", 64'(bus.WM_busy), 64'(1));
      checkOutput("len0_done_early", 64'(bus.WM_done), 64'(0));
      step(1);
      checkOutput("len0_done", 64'(bus.WM_done), 64'(1));
      checkOutput("len0_idle", 64'(bus.WM_busy), 64'(0));
      step(3);
      checkOutput("len0_no_write", 64'(beatCount - base), 64'(0));
      checkOutput("len0_done_sticky", 64'(bus.WM_done), 64'(1));

      checkOutput("readrequest_protocol", 64'(rrErrors), 64'(0));
      checkOutput("pop_while_empty", 64'(emptyErrors), 64'(0));
      checkOutput("burst_stable", 64'(stableErrors), 64'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end
endmodule
